// File: rtl/left_shift_seq_if.sv
// left_shift_seq_if: request/response handshake bundle for the sequential left shifter
interface left_shift_seq_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [CNT_W-1:0] cnt;
    logic             op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, cnt, op, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, cnt, op, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/left_shift_seq.sv
// left_shift_seq: multi-cycle left shift/rotate, one power-of-two barrel stage per clock
module left_shift_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input logic               clk,
    input logic               rst_n,
    left_shift_seq_if.slave   bus_if
);
    localparam int SW = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q;
    logic [SW-1:0]      stage_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   data_d;
    logic [WIDTH-1:0]   out_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               op_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [CNT_W-1:0]   amt_w;
    logic [2*WIDTH-1:0] dbl_w;

    // Stage k shifts by 2^k; the low half of the doubled word supplies either
    // zero fill (logical) or the wrapped-around MSBs (rotate).
    always_comb begin
        amt_w  = CNT_W'(1) << stage_q;
        dbl_w  = {data_q, op_q ? data_q : {WIDTH{1'b0}}} << amt_w;
        data_d = cnt_q[stage_q] ? dbl_w[2*WIDTH-1:WIDTH] : data_q;
    end

    // Control FSM with registered handshake outputs; the result is latched
    // separately so Out survives into IDLE and the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stage_q     <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            op_q        <= 1'b0;
            out_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_if.in_valid) begin
                        data_q     <= bus_if.in_data;
                        cnt_q      <= bus_if.cnt;
                        op_q       <= bus_if.op;
                        stage_q    <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    data_q  <= data_d;
                    stage_q <= stage_q + SW'(1);
                    if (stage_q == SW'(CNT_W - 1)) begin
                        out_q       <= data_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus_if.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_if.in_ready  = in_ready_q;
    assign bus_if.out_valid = out_valid_q;
    assign bus_if.out_data  = out_q;
endmodule

// File: tb/tb_left_shift_seq.sv
// tb_left_shift_seq: scoreboard bench for the sequential left shifter
module tb_left_shift_seq;
    localparam int W = 16;
    localparam int C = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    left_shift_seq_if #(.WIDTH(W), .CNT_W(C)) bus ();
    left_shift_seq #(.WIDTH(W), .CNT_W(C)) dut (.clk(clk), .rst_n(rst_n), .bus_if(bus.slave));

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int last_deliv = 0;
    bit chk_b2b = 0;
    bit prev_valid = 0;
    bit prev_hs = 0;
    bit rand_done = 0;
    logic [W-1:0] held;
    logic [W-1:0] exp_q[$];
    int acc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: full shift/rotate by the whole count in one arithmetic step.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [C-1:0] c, input logic o);
        logic [2*W-1:0] x;
        x = {{W{1'b0}}, d} << c;
        return o ? (x[W-1:0] | x[2*W-1:W]) : x[W-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on each delivery and checks handshake rules.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 0;
            prev_hs = 0;
        end else begin
            if (prev_hs) begin
                check("in_ready_after_deliver", bus.in_ready, 1);
                check("out_valid_drop", bus.out_valid, 0);
            end
            if (bus.out_valid) begin
                check("in_ready_busy", bus.in_ready, 0);
                if (!prev_valid) begin
                    held = bus.out_data;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_result: got %0h expected none", bus.out_data);
                    end else
                        check("latency", cyc - acc_q[0], C);
                end else
                    check("hold_stable", bus.out_data, held);
                if (bus.out_ready) begin
                    if (exp_q.size() != 0) begin
                        check("result", bus.out_data, exp_q.pop_front());
                        void'(acc_q.pop_front());
                    end
                    last_deliv = cyc + 1;
                end
            end
            prev_hs = bus.out_valid && bus.out_ready;
            prev_valid = bus.out_valid;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [C-1:0] c, input logic o);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: in_ready 0 expected 1");
            return;
        end
        if (chk_b2b) check("b2b_gap", cyc + 1 - last_deliv, 1);
        bus.in_data = d;
        bus.cnt = c;
        bus.op = o;
        bus.in_valid = 1'b1;
        exp_q.push_back(model(d, c, o));
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data = W'($urandom);
        bus.cnt = C'($urandom);
        bus.op = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.cnt = '0;
        bus.op = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out", bus.out_data, 0);
        rst_n = 1'b1;

        // abort mid-SHIFT: never pushed to the scoreboard
        @(negedge clk);
        bus.in_data = 16'hABCD;
        bus.cnt = 4'd4;
        bus.op = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_out", bus.out_data, 0);
        check("abort_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) n++;
        end
        check("abort_no_result", n, 0);
        check("abort_idle_ready", bus.in_ready, 1);

        // directed boundary cases
        send(16'h00F1, 4'd4, 1'b0);
        send(16'h1234, 4'd8, 1'b1);
        send(16'hFFFF, 4'd15, 1'b0);
        send(16'h8001, 4'd15, 1'b1);
        send(16'h5A5A, 4'd0, 1'b0);
        send(16'h5A5A, 4'd0, 1'b1);
        wait_idle();

        // backpressure with a stray request while busy
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send(16'hC3A5, 4'd5, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid", bus.out_valid, 1);
        @(negedge clk);
        bus.in_data = 16'hFFFF;
        bus.cnt = 4'd1;
        bus.op = 1'b0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_idle();

        // back-to-back with out_ready tied high
        chk_b2b = 0;
        send(16'h0001, 4'd1, 1'b0);
        chk_b2b = 1;
        send(16'h8000, 4'd1, 1'b1);
        send(16'hF00F, 4'd12, 1'b1);
        wait_idle();
        chk_b2b = 0;

        // random traffic with random backpressure
        fork
            begin
                for (int i = 0; i < 40; i++)
                    send(W'($urandom), C'($urandom), 1'($urandom));
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1 bus.out_ready = 1'($urandom);
                end
            end
        join
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/left_shift_seq.md
Name: left_shift_seq

Overview:
- Multi-cycle 16-bit left shifter/rotator: the left-direction counterpart to the datapath's right-shift barrel stages.
- Applies one power-of-two barrel stage per clock (by 1, 2, 4, then 8), selected by the corresponding bit of the shift count.
- Sits beside the ALU as a shared, low-area shift unit for SLL and ROL instructions.
- Uses a valid/ready handshake on both the input side and the output side.

Parameters:
- WIDTH, 16, data width in bits; must be a power of two.
- CNT_W, 4, shift-count width; equals log2(WIDTH), and is also the number of stage cycles.

Ports:
- clk  input  1  system clock; rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present on In/Cnt/Op
- in_ready  output  1  unit can accept a request
- In  input  WIDTH  operand
- Cnt  input  CNT_W  shift amount, 0..WIDTH-1
- Op  input  1  0 = shift left logical (zero fill); 1 = rotate left
- out_valid  output  1  Out holds a completed result
- out_ready  input  1  consumer accepts Out
- Out  output  WIDTH  result

Behaviour:
- Reset is asynchronous, active-low, one clock. When rst_n=0:
  - state = IDLE, stage index = 0;
  - data register = 0, count register = 0, op register = 0;
  - out_valid = 0, Out = 0, in_ready = 1.
- Reset asserted mid-operation aborts the operation immediately. No result is ever presented for an aborted request.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- IDLE -> SHIFT on the edge where in_valid && in_ready.
  - In, Cnt and Op are registered on that edge.
  - Stage index is set to 0.
- SHIFT, one stage per edge. At each edge, with stage index k:
  - if Cnt_reg[k]=1, data is shifted left by 2^k; otherwise data passes unchanged.
  - Op_reg=0: vacated LSBs are filled with 0.
  - Op_reg=1: bits shifted out of the MSB end re-enter at the LSB end.
  - k increments after each stage. After stage CNT_W-1, the state moves to DONE.
- Latency is fixed and independent of Cnt: out_valid rises CNT_W cycles after the accept edge (4 cycles at the defaults). Cnt=0 still takes the full CNT_W cycles.
- DONE:
  - Out is driven from the data register and held stable while out_valid=1 and out_ready=0.
  - On the edge with out_valid && out_ready, the state returns to IDLE. in_ready reads 1 in the next cycle.
- Only one request is in flight at a time. There is no overlap of accept and deliver.
- in_valid while in_ready=0 is ignored. In/Cnt/Op changes during SHIFT or DONE do not affect the result.
- out_ready while out_valid=0 has no effect.
- Out keeps the last result after returning to IDLE. Out is only meaningful while out_valid=1.
- Minimum throughput: one request per CNT_W+2 cycles when out_ready is tied to 1.

Test Plan:
- Reset → response: hold rst_n=0 mid-SHIFT (accept In=16'hABCD, drop rst_n after 2 cycles) → out_valid=0 and Out=16'h0000 immediately. After release, in_ready=1 and no result is delivered.
- SLL small count: In=16'h00F1, Cnt=4, Op=0, out_ready=1 → out_valid rises exactly 4 cycles after accept, Out=16'h0F10.
- ROL by 8: In=16'h1234, Cnt=8, Op=1 → Out=16'h3412.
- Boundary counts:
  - In=16'hFFFF, Cnt=15, Op=0 → Out=16'h8000.
  - In=16'h8001, Cnt=15, Op=1 → Out=16'hC000.
  - In=16'h5A5A, Cnt=0 → Out=16'h5A5A, still with 4-cycle latency.
- Backpressure and input isolation:
  - out_ready=0 for 5 cycles after out_valid → Out stays stable and in_ready stays 0.
  - A second in_valid pulse with new In during busy is ignored; the first result is unchanged.
  - After out_ready=1, in_ready=1 on the next cycle.
- Back-to-back requests: three requests with out_ready tied to 1 → each accepted one cycle after the prior delivery. Results arrive in order, and no accept occurs while out_valid=1.
